// File: rtl/sc_pkg.sv
// Shared constants, op descriptor payload and helpers for the SC decoder sequencer.
package sc_pkg;

  localparam int unsigned N          = 1024;
  localparam int unsigned P          = 64;
  localparam int unsigned LOAD_BEATS = N / P;
  localparam int unsigned NV_W       = 11;
  localparam int unsigned K_W        = 10;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned CC_W       = 5;
  localparam int unsigned BIT_W      = 13;
  localparam int unsigned BEAT_SHIFT = $clog2(2 * P);

  // Op types
  localparam logic [OP_W-1:0] TYPE1FUN  = 4'd0;
  localparam logic [OP_W-1:0] TYPE2FUN  = 4'd1;
  localparam logic [OP_W-1:0] BOTTOMFUN = 4'd2;
  localparam logic [OP_W-1:0] TYPE3FUN  = 4'd3;

  // FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;

  // One op beat: type, node size, node index in its layer, beat within op
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [NV_W-1:0]  nv;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] cnt;
  } op_desc_t;

  // Beats an op at node size nv occupies: max(1, nv/(2P))
  function automatic logic [CNT_W-1:0] beats(input logic [NV_W-1:0] nv);
    logic [NV_W-1:0] q;
    q = nv >> BEAT_SHIFT;
    if (q == '0) begin
      return CNT_W'(1);
    end
    return CNT_W'(q);
  endfunction

endpackage

// File: rtl/sc_sched_ctrl_if.sv
// Sequencer <-> datapath handshake and op-stream bundle.
interface sc_sched_ctrl_if;
  import sc_pkg::*;

  logic              start;
  logic              ch_valid;
  logic              channel;
  logic [CC_W-1:0]   channel_count;
  logic              channel_ready;
  logic [NV_W-1:0]   I_Nv;
  logic [NV_W-1:0]   I_Nv_next;
  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  counter_next;
  logic [K_W-1:0]    address1;
  logic [K_W-1:0]    address1_next;
  logic [OP_W-1:0]   op_type;
  logic [OP_W-1:0]   op_type_next;
  logic [BIT_W-1:0]  O_bit_count;
  logic              busy;
  logic              done;

  // Sequencer side
  modport master (
    input  start, ch_valid,
    output channel, channel_count, channel_ready,
           I_Nv, I_Nv_next, counter, counter_next,
           address1, address1_next, op_type, op_type_next,
           O_bit_count, busy, done
  );

  // Datapath / frame source side
  modport slave (
    output start, ch_valid,
    input  channel, channel_count, channel_ready,
           I_Nv, I_Nv_next, counter, counter_next,
           address1, address1_next, op_type, op_type_next,
           O_bit_count, busy, done
  );

endinterface

// File: rtl/sc_next_op.sv
// Combinational successor of an op beat in the depth-first tree walk.
module sc_next_op
  import sc_pkg::*;
(
  input  op_desc_t i_cur,
  output op_desc_t o_nxt,
  output logic     o_last
);

  logic [CNT_W-1:0] w_last_beat;
  logic [NV_W-1:0]  w_half;

  // Advance beat, or step to child (F/G) or parent (LEAF/COMB) on the last beat
  always_comb begin
    w_last_beat = beats(i_cur.nv) - CNT_W'(1);
    w_half      = i_cur.nv >> 1;
    o_nxt       = i_cur;
    o_nxt.cnt   = i_cur.cnt + CNT_W'(1);
    o_last      = 1'b0;
    if (i_cur.cnt == w_last_beat) begin
      o_nxt.cnt = '0;
      case (i_cur.op)
        TYPE1FUN, TYPE2FUN: begin
          // Left child for F, right child for G; size-2 children are leaves
          o_nxt.nv = w_half;
          o_nxt.k  = {i_cur.k[K_W-2:0], (i_cur.op == TYPE2FUN)};
          o_nxt.op = (w_half == NV_W'(2)) ? TYPE3FUN : TYPE1FUN;
        end
        default: begin
          if ((i_cur.op == BOTTOMFUN) && (i_cur.nv == NV_W'(N))) begin
            // Root combine finished: frame over
            o_nxt  = '0;
            o_last = 1'b1;
          end else begin
            // Back to parent: left child returning -> G, right child -> COMB
            o_nxt.nv = {i_cur.nv[NV_W-2:0], 1'b0};
            o_nxt.k  = {1'b0, i_cur.k[K_W-1:1]};
            o_nxt.op = i_cur.k[0] ? BOTTOMFUN : TYPE2FUN;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sc_sched_ctrl.sv
// SC decoder sequencer: channel LLR load, then depth-first op stream with lookahead.
module sc_sched_ctrl
  import sc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sc_sched_ctrl_if.master  bus
);

  logic [1:0]       r_state;
  logic [CC_W-1:0]  r_cc;
  op_desc_t         r_cur;
  logic [BIT_W-1:0] r_bits;
  logic             r_done;
  logic             r_busy;
  logic             r_channel;

  logic [1:0]       w_state_nx;
  logic [CC_W-1:0]  w_cc_nx;
  op_desc_t         w_cur_nx;
  logic [BIT_W-1:0] w_bits_nx;
  logic             w_done_nx;
  logic             w_busy_nx;
  logic             w_channel_nx;
  op_desc_t         w_succ;
  logic             w_succ_last;

  sc_next_op u_next_op (
    .i_cur  (r_cur),
    .o_nxt  (w_succ),
    .o_last (w_succ_last)
  );

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cc      <= '0;
      r_cur     <= '0;
      r_bits    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_channel <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cc      <= w_cc_nx;
      r_cur     <= w_cur_nx;
      r_bits    <= w_bits_nx;
      r_done    <= w_done_nx;
      r_busy    <= w_busy_nx;
      r_channel <= w_channel_nx;
    end
  end

  // Next-state and next-output logic; op fields are zero outside DECODE
  always_comb begin
    w_state_nx = r_state;
    w_cc_nx    = r_cc;
    w_cur_nx   = '0;
    w_bits_nx  = r_bits;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nx = ST_LOAD;
          w_cc_nx    = '0;
          w_bits_nx  = '0;
        end
      end
      ST_LOAD: begin
        if (bus.ch_valid) begin
          if (r_cc == CC_W'(LOAD_BEATS - 1)) begin
            w_state_nx   = ST_DECODE;
            w_cc_nx      = '0;
            w_cur_nx.op  = TYPE1FUN;
            w_cur_nx.nv  = NV_W'(N);
          end else begin
            w_cc_nx = r_cc + CC_W'(1);
          end
        end
      end
      ST_DECODE: begin
        if (w_succ_last) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_cur_nx = w_succ;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // Leaf results are counted as the leaf's last beat is presented
    if ((w_state_nx == ST_DECODE) && (w_cur_nx.op == TYPE3FUN) &&
        (w_cur_nx.cnt == beats(w_cur_nx.nv) - CNT_W'(1))) begin
      w_bits_nx = r_bits + BIT_W'(2);
    end

    w_done_nx    = (w_state_nx == ST_DECODE) && (w_cur_nx.op == BOTTOMFUN) &&
                   (w_cur_nx.nv == NV_W'(N)) &&
                   (w_cur_nx.cnt == beats(NV_W'(N)) - CNT_W'(1));
    w_busy_nx    = (w_state_nx != ST_IDLE);
    w_channel_nx = (w_state_nx == ST_DECODE);
  end

  // Registered op stream
  assign bus.channel       = r_channel;
  assign bus.channel_count = r_cc;
  assign bus.I_Nv          = r_cur.nv;
  assign bus.counter       = r_cur.cnt;
  assign bus.address1      = r_cur.k;
  assign bus.op_type       = r_cur.op;
  assign bus.O_bit_count   = r_bits;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

  // Lookahead for storage read-ahead and same-cycle channel write strobe
  assign bus.I_Nv_next     = w_cur_nx.nv;
  assign bus.counter_next  = w_cur_nx.cnt;
  assign bus.address1_next = w_cur_nx.k;
  assign bus.op_type_next  = w_cur_nx.op;
  assign bus.channel_ready = bus.ch_valid & (r_state == ST_LOAD);

endmodule

// File: tb/tb_sc_sched_ctrl.sv
// Scoreboard bench for sc_sched_ctrl: reference tree walk vs. emitted op stream.
module tb_sc_sched_ctrl;

  localparam int CODE_N = 1024;
  localparam int LANES  = 64;

  typedef struct {
    int op;
    int nv;
    int k;
    int cnt;
    int bits;
    bit done;
  } exp_t;

  typedef struct {
    int nv;
    int k;
    int phase;
  } frm_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  exp_t exp_q[$];

  sc_sched_ctrl_if bus_if ();

  sc_sched_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] tup(input int op, input int nv, input int k, input int cnt);
    logic [31:0] t;
    t = {3'b000, op[3:0], nv[10:0], k[9:0], cnt[3:0]};
    return t;
  endfunction

  function automatic logic [31:0] cur_tup();
    return tup(int'(bus_if.op_type), int'(bus_if.I_Nv), int'(bus_if.address1), int'(bus_if.counter));
  endfunction

  function automatic logic [31:0] nxt_tup();
    return tup(int'(bus_if.op_type_next), int'(bus_if.I_Nv_next),
               int'(bus_if.address1_next), int'(bus_if.counter_next));
  endfunction

  function automatic int nbeats(input int nv);
    return (nv / (2 * LANES) == 0) ? 1 : nv / (2 * LANES);
  endfunction

  // Push every beat of one op into the scoreboard
  function automatic void emit(input int op, input int nv, input int k, input int bits);
    int nb;
    nb = nbeats(nv);
    for (int c = 0; c < nb; c++) begin
      exp_t e;
      e.op   = op;
      e.nv   = nv;
      e.k    = k;
      e.cnt  = c;
      e.bits = bits;
      e.done = (op == 2) && (nv == CODE_N) && (c == nb - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Depth-first walk with an explicit stack: F, left subtree, G, right subtree, COMB
  function automatic void build_expected();
    frm_t stk[$];
    frm_t f;
    int   bits;
    bits = 0;
    f.nv = CODE_N; f.k = 0; f.phase = 0;
    stk.push_back(f);
    while (stk.size() > 0) begin
      f = stk.pop_back();
      if (f.nv == 2) begin
        bits += 2;
        emit(3, 2, f.k, bits);
      end else if (f.phase == 0) begin
        frm_t c;
        emit(0, f.nv, f.k, bits);
        f.phase = 1;
        stk.push_back(f);
        c.nv = f.nv / 2; c.k = 2 * f.k; c.phase = 0;
        stk.push_back(c);
      end else if (f.phase == 1) begin
        frm_t c;
        emit(1, f.nv, f.k, bits);
        f.phase = 2;
        stk.push_back(f);
        c.nv = f.nv / 2; c.k = 2 * f.k + 1; c.phase = 0;
        stk.push_back(c);
      end else begin
        emit(2, f.nv, f.k, bits);
      end
    end
  endfunction

  task automatic check_idle(input string pfx);
    chk({pfx, "_op"},    cur_tup(), 32'd0);
    chk({pfx, "_next"},  nxt_tup(), 32'd0);
    chk({pfx, "_flags"}, {28'd0, bus_if.busy, bus_if.done, bus_if.channel, bus_if.channel_ready}, 32'd0);
    chk({pfx, "_bits"},  32'(bus_if.O_bit_count), 32'd0);
    chk({pfx, "_cc"},    32'(bus_if.channel_count), 32'd0);
  endtask

  // start pulse then 16 load beats, optional stall; returns at first DECODE negedge
  task automatic do_load(input int stall_at, input int stall_len);
    int beat;
    int stalls;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    beat   = 0;
    stalls = 0;
    while (beat < CODE_N / LANES) begin
      if (beat == stall_at && stalls < stall_len) begin
        bus_if.ch_valid = 1'b0;
        #1;
        chk("ld_stall_ready", 32'(bus_if.channel_ready), 32'd0);
        chk("ld_stall_count", 32'(bus_if.channel_count), 32'(stall_at));
        stalls++;
      end else begin
        bus_if.ch_valid = 1'b1;
        #1;
        chk("ld_ready", 32'(bus_if.channel_ready), 32'd1);
        chk("ld_count", 32'(bus_if.channel_count), 32'(beat));
        if (beat == 0) begin
          chk("ld_busy_chan", {30'd0, bus_if.busy, bus_if.channel}, 32'd2);
          chk("ld_next_zero", nxt_tup(), 32'd0);
        end
        if (beat == CODE_N / LANES - 1) begin
          chk("ld_next_first_f", nxt_tup(), tup(0, CODE_N, 0, 0));
        end
        beat++;
      end
      @(negedge clk);
    end
    bus_if.ch_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    exp_t e;
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.ch_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;

    // Full frame with a load stall at count 7
    do_load(7, 3);
    #1;
    chk("handoff_chan", 32'(bus_if.channel), 32'd1);
    chk("handoff_op",   cur_tup(), tup(0, CODE_N, 0, 0));

    build_expected();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      e = exp_q.pop_front();
      bus_if.start    = (cyc == 40) || (cyc == 1000);
      bus_if.ch_valid = (cyc % 3 == 0);
      #1;
      chk("op_tuple", cur_tup(), tup(e.op, e.nv, e.k, e.cnt));
      chk("bit_count", 32'(bus_if.O_bit_count), 32'(e.bits));
      chk("done", 32'(bus_if.done), 32'(e.done));
      chk("dec_busy_chan", {30'd0, bus_if.busy, bus_if.channel}, 32'd3);
      if (exp_q.size() > 0) begin
        chk("next_tuple", nxt_tup(), tup(exp_q[0].op, exp_q[0].nv, exp_q[0].k, exp_q[0].cnt));
      end else begin
        chk("next_tuple_end", nxt_tup(), 32'd0);
      end
      if (bus_if.ch_valid) begin
        chk("dec_ch_ready", 32'(bus_if.channel_ready), 32'd0);
      end
      cyc++;
      @(negedge clk);
    end
    bus_if.start    = 1'b0;
    bus_if.ch_valid = 1'b0;
    #1;
    chk("end_busy_chan_done", {29'd0, bus_if.busy, bus_if.channel, bus_if.done}, 32'd0);
    chk("end_op", cur_tup(), 32'd0);

    // Second frame aborted by reset mid root-F
    do_load(-1, 0);
    repeat (3) begin
      #1;
      chk("abort_done_pre", 32'(bus_if.done), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("abort_mid_f", cur_tup(), tup(0, CODE_N, 0, 3));
    #1;
    rst = 1'b0;
    #1;
    check_idle("abort_async");
    @(negedge clk);
    #1;
    check_idle("abort_edge");
    rst = 1'b1;

    // IDLE again: a new start is accepted
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    #1;
    chk("restart_busy_cc", {27'd0, bus_if.busy, bus_if.channel_count}, 32'h20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
